// File: rtl/ng_par_gen_chk.sv
// ng_par_gen_chk : memory parity generator / checker with alarm and error log.
//
// Generate path: GEN_REQ registers the parity bit of WR_DATA onto PAR_OUT,
// held until the next GEN_REQ.
// Check path (3 edges): edge n captures RD_DATA/RD_PAR/RD_ADDR, edge n+1
// registers CHK_VALID/PAR_ERR, edge n+2 applies a failing result to the
// saturating counter, the error log and the NORMAL/ALARM FSM.
//
// Ports:
//   CLK2, GENRST_N               clock, async active-low reset
//   GEN_REQ, WR_DATA -> PAR_OUT  parity generation
//   CHK_REQ, RD_DATA, RD_PAR, RD_ADDR -> CHK_VALID, PAR_ERR
//   ALM_MASK, CLR_ALM -> PARALM, ERR_CNT
//   LOG_POP -> LOG_ADDR, LOG_EMPTY, LOG_OVF   faulting-address log
//
// Optional feature macro: PAR_ERRLOG_EN. When undefined there is no log
// storage: LOG_ADDR=0, LOG_EMPTY=1, LOG_OVF=0 and LOG_POP is ignored.
module ng_par_gen_chk #(
  parameter int DATA_W    = 15,
  parameter int ADDR_W    = 12,
  parameter int ODD       = 1,
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic              CLK2,
  input  logic              GENRST_N,
  input  logic              GEN_REQ,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              PAR_OUT,
  input  logic              CHK_REQ,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic              RD_PAR,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              CHK_VALID,
  output logic              PAR_ERR,
  input  logic              ALM_MASK,
  input  logic              CLR_ALM,
  output logic              PARALM,
  output logic [CNT_W-1:0]  ERR_CNT,
  input  logic              LOG_POP,
  output logic [ADDR_W-1:0] LOG_ADDR,
  output logic              LOG_EMPTY,
  output logic              LOG_OVF
);

  typedef enum logic {NORMAL = 1'b0, ALARM = 1'b1} state_t;

  localparam logic             ODD_B   = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- generate path ----------------
  logic par_q;

  always_ff @(posedge CLK2 or negedge GENRST_N) begin
    if (!GENRST_N)    par_q <= 1'b0;
    else if (GEN_REQ) par_q <= (^WR_DATA) ^ ODD_B;
  end

  assign PAR_OUT = par_q;

  // ---------------- check pipeline ----------------
  // vld_pipe[0]: inputs captured, vld_pipe[1]: result presented (CHK_VALID)
  logic [1:0]        vld_pipe;
  logic [DATA_W-1:0] s1_data;
  logic              s1_par;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W-1:0] s2_addr;
  logic              err_q;

  always_ff @(posedge CLK2 or negedge GENRST_N) begin
    if (!GENRST_N) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_par   <= 1'b0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], CHK_REQ};
      if (CHK_REQ) begin
        s1_data <= RD_DATA;
        s1_par  <= RD_PAR;
        s1_addr <= RD_ADDR;
      end
      // error is forced low outside a valid slot so PAR_ERR never glitches
      err_q   <= vld_pipe[0] & (((^s1_data) ^ ODD_B) != s1_par);
      s2_addr <= s1_addr;
    end
  end

  assign CHK_VALID = vld_pipe[1];
  assign PAR_ERR   = err_q;

  // stage-2 event: a failing result is being retired this edge
  logic err2;
  assign err2 = vld_pipe[1] & err_q;

  // ---------------- saturating error counter ----------------
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK2 or negedge GENRST_N) begin
    if (!GENRST_N)               cnt_q <= '0;
    else if (CLR_ALM)            cnt_q <= err2 ? CNT_W'(1) : '0;  // error wins over clear
    else if (err2 && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ERR_CNT = cnt_q;

  // ---------------- alarm FSM ----------------
  state_t state, state_nxt;

  always_ff @(posedge CLK2 or negedge GENRST_N) begin
    if (!GENRST_N) state <= NORMAL;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (err2 && !ALM_MASK) state_nxt = ALARM;   // unmasked error beats CLR_ALM
    else if (CLR_ALM)      state_nxt = NORMAL;
  end

  always_comb begin
    PARALM = (state == ALARM);
  end

`ifdef PAR_ERRLOG_EN
  // ---------------- error-address log ----------------
  localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(LOG_DEPTH);

  logic [ADDR_W-1:0] mem [LOG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    occ;
  logic              ovf_q;
  logic              full, empty, do_pop, do_push, drop;

  assign full    = (occ == DEPTH_C);
  assign empty   = (occ == '0);
  assign do_pop  = LOG_POP & ~empty;
  // a pop in the same cycle frees the slot, so push into a full log is legal then
  assign do_push = err2 & (~full | do_pop);
  assign drop    = err2 & full & ~do_pop;

  always_ff @(posedge CLK2) begin
    if (do_push) mem[wr_ptr] <= s2_addr;
  end

  always_ff @(posedge CLK2 or negedge GENRST_N) begin
    if (!GENRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // depth is a power of 2, so pointers wrap naturally
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
      if (CLR_ALM)   ovf_q <= drop;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  assign LOG_ADDR  = empty ? '0 : mem[rd_ptr];
  assign LOG_EMPTY = empty;
  assign LOG_OVF   = ovf_q;
`else
  logic unused_log;
  assign unused_log = ^{LOG_POP, s2_addr};
  assign LOG_ADDR   = '0;
  assign LOG_EMPTY  = 1'b1;
  assign LOG_OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_ng_par_gen_chk.sv
// Self-checking bench for ng_par_gen_chk: directed test-plan sequence plus
// random traffic, compared every cycle against a behavioural model.
// A second instance (ODD=0, CNT_W=2) is fed the inverted read parity so its
// error stream matches the first; it exercises even parity and saturation.
module tb_ng_par_gen_chk;
  localparam int DW = 15;
  localparam int AW = 12;
  localparam int DEPTH = 4;

  logic          CLK2 = 1'b0;
  logic          GENRST_N = 1'b0;
  logic          GEN_REQ = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          CHK_REQ = 1'b0;
  logic [DW-1:0] RD_DATA = '0;
  logic          RD_PAR = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic          ALM_MASK = 1'b0;
  logic          CLR_ALM = 1'b0;
  logic          LOG_POP = 1'b0;

  logic          PAR_OUT, CHK_VALID, PAR_ERR, PARALM, LOG_EMPTY, LOG_OVF;
  logic [7:0]    ERR_CNT;
  logic [AW-1:0] LOG_ADDR;

  logic          par_out_e, chk_valid_e, par_err_e, paralm_e, log_empty_e, log_ovf_e;
  logic [1:0]    err_cnt_e;
  logic [AW-1:0] log_addr_e;
  logic          rd_par_e;
  assign rd_par_e = ~RD_PAR;

  always #5 CLK2 = ~CLK2;

  ng_par_gen_chk #(.DATA_W(DW), .ADDR_W(AW), .ODD(1), .CNT_W(8), .LOG_DEPTH(DEPTH)) dut (
    .CLK2(CLK2), .GENRST_N(GENRST_N), .GEN_REQ(GEN_REQ), .WR_DATA(WR_DATA),
    .PAR_OUT(PAR_OUT), .CHK_REQ(CHK_REQ), .RD_DATA(RD_DATA), .RD_PAR(RD_PAR),
    .RD_ADDR(RD_ADDR), .CHK_VALID(CHK_VALID), .PAR_ERR(PAR_ERR), .ALM_MASK(ALM_MASK),
    .CLR_ALM(CLR_ALM), .PARALM(PARALM), .ERR_CNT(ERR_CNT), .LOG_POP(LOG_POP),
    .LOG_ADDR(LOG_ADDR), .LOG_EMPTY(LOG_EMPTY), .LOG_OVF(LOG_OVF));

  ng_par_gen_chk #(.DATA_W(DW), .ADDR_W(AW), .ODD(0), .CNT_W(2), .LOG_DEPTH(DEPTH)) dut_e (
    .CLK2(CLK2), .GENRST_N(GENRST_N), .GEN_REQ(GEN_REQ), .WR_DATA(WR_DATA),
    .PAR_OUT(par_out_e), .CHK_REQ(CHK_REQ), .RD_DATA(RD_DATA), .RD_PAR(rd_par_e),
    .RD_ADDR(RD_ADDR), .CHK_VALID(chk_valid_e), .PAR_ERR(par_err_e), .ALM_MASK(ALM_MASK),
    .CLR_ALM(CLR_ALM), .PARALM(paralm_e), .ERR_CNT(err_cnt_e), .LOG_POP(LOG_POP),
    .LOG_ADDR(log_addr_e), .LOG_EMPTY(log_empty_e), .LOG_OVF(log_ovf_e));

  int n_chk = 0;
  int n_pass = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit            m_par = 0, m_par_e = 0, m_vld = 0, m_err = 0, m_alm = 0, m_ovf = 0;
  int            m_cnt = 0;           // unsaturated count since last clear
  logic [AW-1:0] m_log[$];
  bit            h_req[4], h_err[4];  // per-edge capture history
  logic [AW-1:0] h_addr[4];
  int            cyc = 0;

  initial begin
    forever begin
      @(posedge CLK2 or negedge GENRST_N);
      if (!GENRST_N) begin
        m_par = 0; m_par_e = 0; m_vld = 0; m_err = 0; m_alm = 0; m_ovf = 0;
        m_cnt = 0; m_log.delete(); cyc = 0;
        for (int i = 0; i < 4; i++) begin h_req[i] = 0; h_err[i] = 0; h_addr[i] = '0; end
      end else begin
        automatic int  p1 = (cyc + 3) % 4;   // captured one edge ago
        automatic int  p2 = (cyc + 2) % 4;   // captured two edges ago
        automatic bit  e2 = h_req[p2] && h_err[p2];
        automatic bit  pop;
        if (GEN_REQ) begin
          m_par   = ($countones(WR_DATA) % 2) == 0;  // make total ones odd
          m_par_e = ($countones(WR_DATA) % 2) == 1;  // make total ones even
        end
        m_vld = h_req[p1];
        m_err = h_req[p1] && h_err[p1];
        if (CLR_ALM) begin m_cnt = 0; m_alm = 0; m_ovf = 0; end
        if (e2) begin
          m_cnt++;
          if (!ALM_MASK) m_alm = 1;
        end
`ifdef PAR_ERRLOG_EN
        pop = LOG_POP && (m_log.size() > 0);
        if (pop) void'(m_log.pop_front());
        if (e2) begin
          if (m_log.size() < DEPTH) m_log.push_back(h_addr[p2]);
          else m_ovf = 1;
        end
`else
        pop = 0;
`endif
        h_req[cyc % 4]  = CHK_REQ;
        h_err[cyc % 4]  = (($countones(RD_DATA) + RD_PAR) % 2) != 1;
        h_addr[cyc % 4] = RD_ADDR;
        cyc++;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK2);
      cmp("par_out", PAR_OUT, m_par);
      cmp("par_out_even", par_out_e, m_par_e);
      cmp("chk_valid", CHK_VALID, m_vld);
      cmp("chk_valid_e", chk_valid_e, m_vld);
      if (m_vld) begin
        cmp("par_err", PAR_ERR, m_err);
        cmp("par_err_e", par_err_e, m_err);
      end
      cmp("paralm", PARALM, m_alm);
      cmp("paralm_e", paralm_e, m_alm);
      cmp("err_cnt", ERR_CNT, (m_cnt > 255) ? 255 : m_cnt);
      cmp("err_cnt_sat", err_cnt_e, (m_cnt > 3) ? 3 : m_cnt);
      cmp("log_empty", LOG_EMPTY, m_log.size() == 0);
      cmp("log_addr", LOG_ADDR, (m_log.size() == 0) ? '0 : m_log[0]);
      cmp("log_ovf", LOG_OVF, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK2); #1;
  endtask

  task automatic idle();
    GEN_REQ = 0; CHK_REQ = 0; CLR_ALM = 0; LOG_POP = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input bit bad, input logic [DW-1:0] d);
    CHK_REQ = 1; RD_DATA = d; RD_ADDR = a;
    RD_PAR  = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ bad;
  endtask

  initial begin
    // reset state
    tick(); tick();
    cmp("rst_par_out", PAR_OUT, 0);   cmp("rst_chk_valid", CHK_VALID, 0);
    cmp("rst_par_err", PAR_ERR, 0);   cmp("rst_paralm", PARALM, 0);
    cmp("rst_err_cnt", ERR_CNT, 0);   cmp("rst_log_empty", LOG_EMPTY, 1);
    cmp("rst_log_addr", LOG_ADDR, 0); cmp("rst_log_ovf", LOG_OVF, 0);
    GENRST_N = 1;
    tick();

    // generate path
    GEN_REQ = 1; WR_DATA = 15'h0001; tick(); idle();
    cmp("gen_0001_odd", PAR_OUT, 0); cmp("gen_0001_even", par_out_e, 1);
    GEN_REQ = 1; WR_DATA = 15'h0000; tick(); idle();
    cmp("gen_0000_odd", PAR_OUT, 1);
    tick(); cmp("gen_hold", PAR_OUT, 1);

    // good read
    set_rd(12'h100, 0, 15'h0003); tick(); idle();
    cmp("good_rdpar", RD_PAR, 1);
    tick(); cmp("good_valid", CHK_VALID, 1); cmp("good_err", PAR_ERR, 0);
    tick(); cmp("good_alm", PARALM, 0); cmp("good_cnt", ERR_CNT, 0);

    // bad read
    set_rd(12'h2A5, 1, 15'h0003); tick(); idle();
    tick(); cmp("bad_valid", CHK_VALID, 1); cmp("bad_err", PAR_ERR, 1);
    tick(); cmp("bad_alm", PARALM, 1); cmp("bad_cnt", ERR_CNT, 1);
`ifdef PAR_ERRLOG_EN
    cmp("bad_log_addr", LOG_ADDR, 12'h2A5); cmp("bad_log_empty", LOG_EMPTY, 0);
`endif
    LOG_POP = 1; tick(); idle();
    cmp("pop_empty", LOG_EMPTY, 1);

    // masked errors, clear, clear-vs-error race
    CLR_ALM = 1; tick(); idle();
    ALM_MASK = 1;
    for (int i = 0; i < 3; i++) begin set_rd(AW'(12'h10 + i), 1, DW'($urandom)); tick(); end
    idle(); tick(); tick();
    cmp("mask_cnt", ERR_CNT, 3); cmp("mask_alm", PARALM, 0);
    CLR_ALM = 1; tick(); idle();
    cmp("clr_cnt", ERR_CNT, 0);
    ALM_MASK = 0;
    set_rd(12'h013, 1, 15'h1234); tick(); idle(); tick();
    CLR_ALM = 1; tick(); idle();
    cmp("race_alm", PARALM, 1); cmp("race_cnt", ERR_CNT, 1);

    // log overflow and pop-while-full
    LOG_POP = 1; repeat (4) tick(); idle();
    cmp("drain_empty", LOG_EMPTY, 1);
    for (int i = 1; i <= 5; i++) begin set_rd(AW'(i), 1, DW'($urandom)); tick(); end
    idle(); tick(); tick();
    cmp("ovf_cnt", ERR_CNT, 6);
`ifdef PAR_ERRLOG_EN
    cmp("ovf_head", LOG_ADDR, 1); cmp("ovf_flag", LOG_OVF, 1);
`else
    cmp("nolog_empty", LOG_EMPTY, 1); cmp("nolog_ovf", LOG_OVF, 0);
`endif
    CLR_ALM = 1; tick(); idle();
    cmp("ovf_cleared", LOG_OVF, 0);
    set_rd(12'h006, 1, 15'h7777); tick(); idle(); tick();
    LOG_POP = 1; tick();
    cmp("pushpop_ovf", LOG_OVF, 0);
`ifdef PAR_ERRLOG_EN
    cmp("pushpop_head", LOG_ADDR, 2);
    tick(); cmp("pop_order_3", LOG_ADDR, 3);
    tick(); cmp("pop_order_4", LOG_ADDR, 4);
    tick(); cmp("pop_order_6", LOG_ADDR, 6);
`else
    tick(); tick(); tick();
`endif
    tick(); idle();
    cmp("final_empty", LOG_EMPTY, 1);

    // reset between bad check and its stage 2
    CLR_ALM = 1; tick(); idle();
    set_rd(12'h007, 1, 15'h0101); tick(); idle();
    GENRST_N = 0; #1;
    cmp("midrst_valid", CHK_VALID, 0); cmp("midrst_cnt", ERR_CNT, 0);
    cmp("midrst_alm", PARALM, 0);      cmp("midrst_par", PAR_OUT, 0);
    tick(); GENRST_N = 1;
    tick(); tick(); tick();
    cmp("postrst_cnt", ERR_CNT, 0); cmp("postrst_alm", PARALM, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      GEN_REQ  = ($urandom % 2) == 0;
      WR_DATA  = DW'($urandom);
      if (($urandom % 10) < 7) set_rd(AW'($urandom), ($urandom % 10) < 4, DW'($urandom));
      else CHK_REQ = 0;
      ALM_MASK = ($urandom % 4) == 0;
      CLR_ALM  = ($urandom % 25) == 0;
      LOG_POP  = ($urandom % 3) == 0;
      GENRST_N = ($urandom % 600) != 0;
      tick();
      GENRST_N = 1;
    end
    idle(); tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ng_par_gen_chk.md
Name: ng_par_gen_chk

Overview:
- Parametrised successor to the single-channel AGC memory parity generator/checker.
- Generates the parity bit for memory writes and checks read words plus their stored parity.
- Counts errors, raises a sticky maskable parity alarm and logs the faulting addresses.
- Sits between the memory interface and the alarm/restart logic, for both erasable and fixed memory paths.

Parameters:
DATA_W, 15, data bits covered by parity.
ADDR_W, 12, width of the address logged per error.
ODD, 1, 1 = odd parity (total ones incl. parity bit odd), 0 = even.
CNT_W, 8, width of the saturating error counter.
LOG_DEPTH, 4, error-address log entries; power of 2, at least 2.

Ports:
CLK2  in  1  system clock; all state changes on its rising edge.
GENRST_N  in  1  asynchronous active-low reset.
GEN_REQ  in  1  sample WR_DATA and generate parity.
WR_DATA  in  DATA_W  write word.
PAR_OUT  out  1  generated parity bit, registered.
CHK_REQ  in  1  sample RD_DATA/RD_PAR/RD_ADDR for checking.
RD_DATA  in  DATA_W  read word.
RD_PAR  in  1  stored parity bit of the read word.
RD_ADDR  in  ADDR_W  address of the read word.
CHK_VALID  out  1  one-cycle pulse: check result valid.
PAR_ERR  out  1  check failed; qualified by CHK_VALID.
ALM_MASK  in  1  1 = errors are counted and logged but do not raise PARALM.
CLR_ALM  in  1  synchronous clear of PARALM, ERR_CNT and LOG_OVF.
PARALM  out  1  sticky parity alarm.
ERR_CNT  out  CNT_W  saturating error count.
LOG_POP  in  1  pop the head entry of the log.
LOG_ADDR  out  ADDR_W  head entry of the log (first-word fall-through); 0 when the log is empty.
LOG_EMPTY  out  1  log is empty.
LOG_OVF  out  1  sticky flag: an error was dropped because the log was full.

Behaviour:
- Reset (GENRST_N=0, asynchronous): PAR_OUT=0, CHK_VALID=0, PAR_ERR=0, PARALM=0, ERR_CNT=0, LOG_EMPTY=1, LOG_ADDR=0, LOG_OVF=0, FSM=NORMAL, log pointers=0.
- Reset mid-operation aborts any in-flight check; no error is counted.
- Generate path:
  - GEN_REQ high at edge n: PAR_OUT = (^WR_DATA) XOR ODD, valid from n+1.
  - PAR_OUT holds its value until the next GEN_REQ.
- Check path, stage 1:
  - CHK_REQ at edge n: register RD_DATA, RD_PAR and RD_ADDR.
  - At n+1: CHK_VALID=1 and PAR_ERR = ((^RD_DATA) XOR ODD) != RD_PAR.
- Check path, stage 2 (edge n+2, only if PAR_ERR=1):
  - ERR_CNT increments and saturates at 2^CNT_W-1.
  - RD_ADDR is pushed into the log.
  - The FSM evaluates the error.
- Throughput: back-to-back CHK_REQ every cycle is supported. GEN and CHK paths are independent and may fire in the same cycle.
- Alarm FSM, states NORMAL and ALARM:
  - NORMAL -> ALARM on a stage-2 error with ALM_MASK=0.
  - ALARM -> NORMAL on CLR_ALM.
  - PARALM=1 exactly while in ALARM.
  - A masked error never changes state.
  - CLR_ALM in the same cycle as an unmasked stage-2 error: the error wins (state ALARM, ERR_CNT=1, LOG_OVF keeps its cleared value unless this error overflows).
- Error log: circular buffer of LOG_DEPTH entries with wrap-around read/write pointers plus an occupancy count.
  - Push while full: entry dropped, LOG_OVF=1.
  - Push and pop in the same cycle while full: both performed, no overflow.
  - Pop while empty: ignored.
  - CLR_ALM does not flush log entries.

Optional Feature:
- Macro PAR_ERRLOG_EN.
- Defined: error log implemented as described above.
- Undefined: no log storage; LOG_ADDR=0, LOG_EMPTY=1 and LOG_OVF=0 constantly; LOG_POP is ignored. Counter and alarm behaviour are unchanged.

Test Plan:
- Default parameters, GEN_REQ with WR_DATA=15'h0001 -> PAR_OUT=0 next cycle. WR_DATA=15'h0000 -> PAR_OUT=1. With ODD=0, WR_DATA=15'h0001 -> PAR_OUT=1.
- CHK_REQ with RD_DATA=15'h0003, RD_PAR=1, RD_ADDR=12'h100 -> CHK_VALID=1, PAR_ERR=0 one cycle later; PARALM=0, ERR_CNT=0.
- CHK_REQ with RD_DATA=15'h0003, RD_PAR=0, RD_ADDR=12'h2A5 -> PAR_ERR=1 at n+1. At n+2: PARALM=1, ERR_CNT=1, LOG_ADDR=12'h2A5, LOG_EMPTY=0. LOG_POP -> LOG_EMPTY=1.
- ALM_MASK=1, three bad reads -> ERR_CNT=3, PARALM=0. CLR_ALM pulse -> ERR_CNT=0. Unmasked bad read coinciding with CLR_ALM at stage 2 -> PARALM=1, ERR_CNT=1.
- Five consecutive bad reads at addresses 1..5 with LOG_DEPTH=4 -> entries 1..4 retained, LOG_OVF=1. A bad read with LOG_POP while full -> no further drop. Pops return addresses in order.
- Assert GENRST_N=0 between a bad CHK_REQ and its stage 2 -> all outputs at reset values, ERR_CNT stays 0 after release. With PAR_ERRLOG_EN undefined -> LOG_EMPTY=1 throughout.
